// File: rtl/regfile_seq.sv
// Bulk-access sequencer for a 16x16 register file: dumps a register range
// over a valid/ready stream, or loads a valid/ready stream into the range.
module regfile_seq #(
  parameter int START_REG = 0,
  parameter int END_REG   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_dump,
  input  logic        start_load,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  SrcReg1,
  input  logic [15:0] SrcData1,
  output logic [3:0]  DstReg,
  output logic        WriteReg,
  output logic [15:0] DstData,
  output logic [15:0] dump_data,
  output logic [3:0]  dump_idx,
  output logic        dump_valid,
  input  logic        dump_ready,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] START_IDX = START_REG[3:0];
  localparam logic [3:0] END_IDX   = END_REG[3:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DUMP_RD   = 3'd1,
    S_DUMP_SEND = 3'd2,
    S_LOAD      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] dump_data_q, dump_data_d;
  logic [3:0]  dump_idx_q, dump_idx_d;

  // Handshakes: a dump word moves when dump_valid & dump_ready are both high
  // at a rising edge; a load word moves when load_valid & load_ready are both
  // high at a rising edge. Neither valid depends on its ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= START_IDX;
      dump_data_q <= 16'h0000;
      dump_idx_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_data_q <= dump_data_d;
      dump_idx_q  <= dump_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_data_d = dump_data_q;
    dump_idx_d  = dump_idx_q;
    busy        = 1'b0;
    done        = 1'b0;
    dump_valid  = 1'b0;
    load_ready  = 1'b0;
    WriteReg    = 1'b0;
    DstReg      = 4'h0;
    DstData     = 16'h0000;
    SrcReg1     = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_dump) begin
          state_d = S_DUMP_RD;
          idx_d   = START_IDX;
        end else if (start_load) begin
          state_d = S_LOAD;
          idx_d   = START_IDX;
        end
      end
      S_DUMP_RD: begin
        busy        = 1'b1;
        dump_data_d = SrcData1;
        dump_idx_d  = idx_q;
        state_d     = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == END_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_DUMP_RD;
          end
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        DstReg     = idx_q;
        DstData    = load_data;
        // The register file commits on this same edge, so abort must gate it.
        WriteReg   = load_valid & ~abort & ~rst;
        if (load_valid) begin
          if (idx_q == END_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      dump_data_d = 16'h0000;
      dump_idx_d  = 4'h0;
    end
  end

  assign dump_data = dump_data_q;
  assign dump_idx  = dump_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Randomized scoreboard bench for regfile_seq: a behavioural register-file
// model predicts every dump word and every register write.
module tb_regfile_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_dump, start_load, abort;
  logic        busy, done;
  logic [3:0]  SrcReg1, DstReg, dump_idx;
  logic [15:0] SrcData1, DstData, dump_data, load_data;
  logic        WriteReg, dump_valid, dump_ready, load_valid, load_ready;
  logic [2:0]  dbg_state;

  logic        start_dump2, start_load2, abort2;
  logic        busy2, done2;
  logic [3:0]  SrcReg1_2, DstReg2, dump_idx2;
  logic [15:0] SrcData1_2, DstData2, dump_data2, load_data2;
  logic        WriteReg2, dump_valid2, dump_ready2, load_valid2, load_ready2;
  logic [2:0]  dbg_state2;

  logic [15:0] rf [16];
  logic [15:0] rf2 [16];
  logic [15:0] model_rf [16];

  logic [19:0] exp_q[$];
  logic [19:0] exp_wr_q[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_word = 20'h0;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk(clk), .rst(rst), .start_dump(start_dump), .start_load(start_load),
    .abort(abort), .busy(busy), .done(done), .SrcReg1(SrcReg1),
    .SrcData1(SrcData1), .DstReg(DstReg), .WriteReg(WriteReg),
    .DstData(DstData), .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .dbg_state(dbg_state)
  );

  regfile_seq #(.START_REG(3), .END_REG(3)) dut2 (
    .clk(clk), .rst(rst), .start_dump(start_dump2), .start_load(start_load2),
    .abort(abort2), .busy(busy2), .done(done2), .SrcReg1(SrcReg1_2),
    .SrcData1(SrcData1_2), .DstReg(DstReg2), .WriteReg(WriteReg2),
    .DstData(DstData2), .dump_data(dump_data2), .dump_idx(dump_idx2),
    .dump_valid(dump_valid2), .dump_ready(dump_ready2), .load_data(load_data2),
    .load_valid(load_valid2), .load_ready(load_ready2), .dbg_state(dbg_state2)
  );

  // Register file environment: combinational read, write on rising edge.
  assign SrcData1   = rf[SrcReg1];
  assign SrcData1_2 = rf2[SrcReg1_2];
  always @(posedge clk) if (WriteReg) rf[DstReg] <= DstData;
  always @(posedge clk) if (WriteReg2) rf2[DstReg2] <= DstData2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: dump words, hold-while-stalled, and register writes.
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst) begin
      if (dump_valid && dump_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dump_unexpected: got idx %h data %h expected no word", dump_idx, dump_data);
        end else begin
          checks--;
          e = exp_q.pop_front();
          check("dump_word", {12'h0, dump_idx, dump_data}, {12'h0, e});
        end
      end
      if (prev_stall && dump_valid)
        check("dump_hold", {12'h0, dump_idx, dump_data}, {12'h0, prev_word});
      prev_stall = dump_valid && !dump_ready;
      prev_word  = {dump_idx, dump_data};
    end else begin
      prev_stall = 1'b0;
    end
    if (WriteReg) begin
      wr_count++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got reg %h data %h expected no write", DstReg, DstData);
      end else begin
        checks--;
        e = exp_wr_q.pop_front();
        check("write", {12'h0, DstReg, DstData}, {12'h0, e});
      end
    end
  end

  // mode 0: valid every cycle, 1: pattern 1,0,0, 2: random.
  task automatic do_load(input logic [15:0] base, input int mode, input int abort_at);
    int   words;
    int   k;
    logic v;
    wr_count = 0;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    words = 0;
    k = 0;
    while (words < 16 && k < 200) begin
      if (words == abort_at) begin
        load_valid = 1'b1;
        load_data  = base + 16'(words);
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        load_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_load_ready", 32'(load_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_wr_count", wr_count, abort_at);
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = v ? base + 16'(words) : 16'($urandom);
      if (v && load_ready) begin
        exp_wr_q.push_back({4'(words), base + 16'(words)});
        model_rf[words] = base + 16'(words);
        words++;
      end
      tick();
      k++;
    end
    load_valid = 1'b0;
    check("load_words", words, 16);
    check("load_done", 32'(done), 32'd1);
    check("load_busy_in_done", 32'(busy), 32'd0);
    check("load_write_count", wr_count, 16);
    tick();
    check("load_done_pulse", 32'(done), 32'd0);
    check("load_wr_q_empty", exp_wr_q.size(), 0);
    exp_wr_q.delete();
  endtask

  // mode 0: ready always, 1: toggling with a 5-cycle stall at idx 7, 2: random.
  task automatic do_dump(input int mode, input bit both_start, input bit mid_load);
    int k;
    int busy_cnt;
    int stall;
    bit seen;
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), model_rf[i]});
    start_dump = 1'b1;
    start_load = both_start;
    tick();
    start_dump = 1'b0;
    start_load = 1'b0;
    k = 0;
    busy_cnt = 0;
    stall = 5;
    seen = 1'b0;
    while (k < 400) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (k == 0) check("dump_rd_no_valid", 32'(dump_valid), 32'd0);
      if (k == 1) check("dump_first_valid", 32'(dump_valid), 32'd1);
      case (mode)
        0: dump_ready = 1'b1;
        1: begin
          if (dump_valid && dump_idx == 4'd7 && stall > 0) begin
            dump_ready = 1'b0;
            stall--;
          end else begin
            dump_ready = 1'(k % 2);
          end
        end
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      start_load = mid_load && (k == 6);
      tick();
      k++;
    end
    dump_ready = 1'b0;
    start_load = 1'b0;
    check("dump_done_seen", 32'(seen), 32'd1);
    check("dump_busy_in_done", 32'(busy), 32'd0);
    if (mode == 0) check("dump_busy_cycles", busy_cnt, 32);
    check("dump_q_empty", exp_q.size(), 0);
    exp_q.delete();
    tick();
    check("dump_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    {start_dump, start_load, abort, dump_ready, load_valid} = '0;
    {start_dump2, start_load2, abort2, dump_ready2, load_valid2} = '0;
    load_data  = 16'h0;
    load_data2 = 16'h0;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 16'h0;
      rf2[i] = 16'h0;
      model_rf[i] = 16'h0;
    end
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_data", 32'(dump_data), 32'd0);
    check("rst_dump_idx", 32'(dump_idx), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_write", 32'(WriteReg), 32'd0);
    check("rst_dst", {12'h0, DstReg, DstData}, 32'd0);
    check("rst_src", 32'(SrcReg1), 32'd0);
    rst = 1'b0;
    tick();

    do_load(16'hA000, 0, -1);
    do_dump(0, 1'b0, 1'b0);
    do_dump(1, 1'b0, 1'b0);
    do_load(16'h1234, 1, -1);
    do_dump(0, 1'b1, 1'b1);
    do_load(16'h5500, 0, 5);
    do_dump(2, 1'b0, 1'b0);
    repeat (3) begin
      do_load(16'($urandom), 2, -1);
      do_dump(2, 1'b0, 1'b0);
    end

    // Reset in the middle of a dump.
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), model_rf[i]});
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    dump_ready = 1'b1;
    repeat (12) tick();
    dump_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(dump_valid), 32'd0);
    check("midrst_dump", {12'h0, dump_idx, dump_data}, 32'd0);
    check("midrst_src", 32'(SrcReg1), 32'd0);
    check("midrst_write", 32'(WriteReg), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_no_done", 32'(done), 32'd0);

    // Single-register range instance.
    start_load2 = 1'b1;
    tick();
    start_load2 = 1'b0;
    load_valid2 = 1'b1;
    load_data2  = 16'hBEEF;
    #1;
    check("one_load_ready", 32'(load_ready2), 32'd1);
    check("one_write", {11'h0, WriteReg2, DstReg2, DstData2}, {11'h0, 1'b1, 4'd3, 16'hBEEF});
    tick();
    load_valid2 = 1'b0;
    check("one_load_done", 32'(done2), 32'd1);
    check("one_rf", 32'(rf2[3]), 32'h0000BEEF);
    tick();
    start_dump2 = 1'b1;
    tick();
    start_dump2 = 1'b0;
    dump_ready2 = 1'b1;
    tick();
    check("one_dump_word", {11'h0, dump_valid2, dump_idx2, dump_data2}, {11'h0, 1'b1, 4'd3, 16'hBEEF});
    tick();
    dump_ready2 = 1'b0;
    check("one_dump_done", 32'(done2), 32'd1);
    tick();
    check("one_idle", {30'h0, busy2, done2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
